// File: rtl/mem_arbiter.sv
// Two-port (icache = port 0, dcache = port 1) arbiter onto one memory channel with in-order read routing.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; by default port 1 has fixed priority.
module mem_arbiter #(
  parameter int ADDR_BITS       = 28,
  parameter int DATA_CYCLES     = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int MEM_DATA_BITS   = 128
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       c0_req_val,
  output logic                       c0_req_rdy,
  input  logic [ADDR_BITS-1:0]       c0_req_addr,
  input  logic                       c0_req_rw,
  input  logic                       c0_data_valid,
  output logic                       c0_data_ready,
  input  logic [MEM_DATA_BITS-1:0]   c0_data_bits,
  input  logic [MEM_DATA_BITS/8-1:0] c0_data_mask,
  output logic                       c0_resp_val,
  output logic [MEM_DATA_BITS-1:0]   c0_resp_data,
  input  logic                       c1_req_val,
  output logic                       c1_req_rdy,
  input  logic [ADDR_BITS-1:0]       c1_req_addr,
  input  logic                       c1_req_rw,
  input  logic                       c1_data_valid,
  output logic                       c1_data_ready,
  input  logic [MEM_DATA_BITS-1:0]   c1_data_bits,
  input  logic [MEM_DATA_BITS/8-1:0] c1_data_mask,
  output logic                       c1_resp_val,
  output logic [MEM_DATA_BITS-1:0]   c1_resp_data,
  output logic                       mem_req_val,
  input  logic                       mem_req_rdy,
  output logic [ADDR_BITS-1:0]       mem_req_addr,
  output logic                       mem_req_rw,
  output logic                       mem_req_data_valid,
  input  logic                       mem_req_data_ready,
  output logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
  output logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                       mem_resp_val,
  input  logic [MEM_DATA_BITS-1:0]   mem_resp_data
);

  localparam int BEAT_W = (DATA_CYCLES > 1) ? $clog2(DATA_CYCLES) : 1;
  localparam int PTR_W  = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(DATA_CYCLES - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic {IDLE, WDATA} state_t;

  state_t            state;
  logic              wr_owner;
  logic [BEAT_W-1:0] wr_beat;
  logic [BEAT_W-1:0] rd_beat;
  logic              id_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic              favor1;
`endif

  logic fifo_full, fifo_empty, idle_arb, in_wdata;
  logic elig0, elig1, grant, winner, win_rw;
  logic req_fire, data_fire, push, pop, resp_ok, head_id;

  always_comb begin
    fifo_full  = (count == FULL_CNT);
    fifo_empty = (count == '0);
    idle_arb   = reset && (state == IDLE);
    in_wdata   = reset && (state == WDATA);
    // Writes take no ID slot, so only reads are held back by a full FIFO.
    elig0      = idle_arb && c0_req_val && (c0_req_rw || !fifo_full);
    elig1      = idle_arb && c1_req_val && (c1_req_rw || !fifo_full);
    grant      = elig0 || elig1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    winner     = (elig0 && elig1) ? favor1 : elig1;
`else
    winner     = elig1;
`endif
    win_rw     = winner ? c1_req_rw : c0_req_rw;
    req_fire   = grant && mem_req_rdy;
    push       = req_fire && !win_rw;
    head_id    = id_mem[rd_ptr];
    resp_ok    = mem_resp_val && !fifo_empty;
    pop        = resp_ok && (rd_beat == LAST_BEAT);
  end

  assign mem_req_val  = grant;
  assign mem_req_addr = winner ? c1_req_addr : c0_req_addr;
  assign mem_req_rw   = win_rw;
  assign c0_req_rdy   = req_fire && !winner;
  assign c1_req_rdy   = req_fire && winner;

  assign mem_req_data_valid = in_wdata && (wr_owner ? c1_data_valid : c0_data_valid);
  assign mem_req_data_bits  = wr_owner ? c1_data_bits : c0_data_bits;
  assign mem_req_data_mask  = wr_owner ? c1_data_mask : c0_data_mask;
  assign c0_data_ready      = in_wdata && !wr_owner && mem_req_data_ready;
  assign c1_data_ready      = in_wdata && wr_owner && mem_req_data_ready;
  assign data_fire          = mem_req_data_valid && mem_req_data_ready;

  assign c0_resp_val  = resp_ok && !head_id;
  assign c1_resp_val  = resp_ok && head_id;
  assign c0_resp_data = mem_resp_data;
  assign c1_resp_data = mem_resp_data;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wr_owner <= 1'b0;
      wr_beat  <= '0;
    end else begin
      case (state)
        IDLE: if (req_fire && win_rw) begin
          state    <= WDATA;
          wr_owner <= winner;
          wr_beat  <= '0;
        end
        WDATA: if (data_fire) begin
          if (wr_beat == LAST_BEAT) state <= IDLE;
          wr_beat <= wr_beat + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_beat <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (resp_ok) rd_beat <= (rd_beat == LAST_BEAT) ? '0 : rd_beat + 1'b1;
    end
  end

  // NOTE: ID storage has no reset; count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) id_mem[wr_ptr] <= winner;
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        favor1 <= 1'b0;
    else if (req_fire) favor1 <= !winner;
  end
`endif

`ifndef SYNTHESIS
  resp_without_read: assert property (@(posedge clk) disable iff (!reset) !(mem_resp_val && fifo_empty))
    else $error("mem_resp_val with no outstanding read");
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized reads against a queue model.
// Expected arbitration order follows MEM_ARB_ROUND_ROBIN_EN when it is defined.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AB = 28, DC = 4, MO = 4, DB = 128, MB = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          c0_req_val, c0_req_rdy, c0_req_rw, c0_data_valid, c0_data_ready, c0_resp_val;
  logic [AB-1:0] c0_req_addr;
  logic [DB-1:0] c0_data_bits, c0_resp_data;
  logic [MB-1:0] c0_data_mask;
  logic          c1_req_val, c1_req_rdy, c1_req_rw, c1_data_valid, c1_data_ready, c1_resp_val;
  logic [AB-1:0] c1_req_addr;
  logic [DB-1:0] c1_data_bits, c1_resp_data;
  logic [MB-1:0] c1_data_mask;
  logic          mem_req_val, mem_req_rdy, mem_req_rw, mem_req_data_valid, mem_req_data_ready, mem_resp_val;
  logic [AB-1:0] mem_req_addr;
  logic [DB-1:0] mem_req_data_bits, mem_resp_data;
  logic [MB-1:0] mem_req_data_mask;

  int vectors = 0;
  int errors  = 0;

  mem_arbiter #(.ADDR_BITS(AB), .DATA_CYCLES(DC), .MAX_OUTSTANDING(MO), .MEM_DATA_BITS(DB)) dut (
    .clk(clk), .reset(rst_n),
    .c0_req_val(c0_req_val), .c0_req_rdy(c0_req_rdy), .c0_req_addr(c0_req_addr), .c0_req_rw(c0_req_rw),
    .c0_data_valid(c0_data_valid), .c0_data_ready(c0_data_ready), .c0_data_bits(c0_data_bits),
    .c0_data_mask(c0_data_mask), .c0_resp_val(c0_resp_val), .c0_resp_data(c0_resp_data),
    .c1_req_val(c1_req_val), .c1_req_rdy(c1_req_rdy), .c1_req_addr(c1_req_addr), .c1_req_rw(c1_req_rw),
    .c1_data_valid(c1_data_valid), .c1_data_ready(c1_data_ready), .c1_data_bits(c1_data_bits),
    .c1_data_mask(c1_data_mask), .c1_resp_val(c1_resp_val), .c1_resp_data(c1_resp_data),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_val(mem_resp_val), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    c0_req_val = 0; c0_req_rw = 0; c0_req_addr = '0; c0_data_valid = 0; c0_data_bits = '0; c0_data_mask = '0;
    c1_req_val = 0; c1_req_rw = 0; c1_req_addr = '0; c1_data_valid = 0; c1_data_bits = '0; c1_data_mask = '0;
    mem_req_rdy = 0; mem_req_data_ready = 0; mem_resp_val = 0; mem_resp_data = '0;
  endtask

  // Leaves the bench at a falling edge with reset released and the DUT idle.
  task automatic do_reset();
    idle();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    c0_req_val = 1; c1_req_val = 1; mem_req_rdy = 1; c0_data_valid = 1; c1_data_valid = 1; mem_req_data_ready = 1;
    @(negedge clk); #1;
    vectors++; if (mem_req_val !== 1'b0) begin errors++; $display("FAIL reset_mem_req_val: got %b want 0", mem_req_val); end
    vectors++; if ({c0_req_rdy, c1_req_rdy} !== 2'b00) begin errors++; $display("FAIL reset_req_rdy: got %b want 00", {c0_req_rdy, c1_req_rdy}); end
    vectors++; if ({c0_resp_val, c1_resp_val} !== 2'b00) begin errors++; $display("FAIL reset_resp_val: got %b want 00", {c0_resp_val, c1_resp_val}); end
    vectors++; if ({mem_req_data_valid, c0_data_ready, c1_data_ready} !== 3'b000) begin errors++; $display("FAIL reset_data_hs: got %b want 000", {mem_req_data_valid, c0_data_ready, c1_data_ready}); end
  endtask

  task automatic test_single_read();
    logic [DB-1:0] exp_data;
    do_reset();
    c0_req_val = 1; c0_req_rw = 0; c0_req_addr = 28'h0000040; mem_req_rdy = 1;
    #1;
    vectors++; if ({mem_req_val, mem_req_rw} !== 2'b10) begin errors++; $display("FAIL single_val_rw: got %b want 10", {mem_req_val, mem_req_rw}); end
    vectors++; if (mem_req_addr !== 28'h0000040) begin errors++; $display("FAIL single_addr: got %h want 0000040", mem_req_addr); end
    vectors++; if ({c0_req_rdy, c1_req_rdy} !== 2'b10) begin errors++; $display("FAIL single_rdy: got %b want 10", {c0_req_rdy, c1_req_rdy}); end
    @(negedge clk);
    c0_req_val = 0; #1;
    vectors++; if (mem_req_val !== 1'b0) begin errors++; $display("FAIL single_one_fire: got %b want 0", mem_req_val); end
    for (int i = 0; i < DC; i++) begin
      @(negedge clk);
      exp_data = {4{32'hA000_0000 + 32'(i)}};
      mem_resp_val = 1; mem_resp_data = exp_data; #1;
      vectors++; if ({c0_resp_val, c1_resp_val} !== 2'b10) begin errors++; $display("FAIL single_resp_val beat %0d: got %b want 10", i, {c0_resp_val, c1_resp_val}); end
      vectors++; if (c0_resp_data !== exp_data) begin errors++; $display("FAIL single_resp_data beat %0d: got %h want %h", i, c0_resp_data, exp_data); end
    end
    @(negedge clk);
    mem_resp_val = 0; #1;
    vectors++; if (c0_resp_val !== 1'b0) begin errors++; $display("FAIL single_resp_end: got %b want 0", c0_resp_val); end
    @(negedge clk);
  endtask

  task automatic test_dual_read();
    int first;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    first = 0;
`else
    first = 1;
`endif
    do_reset();
    c0_req_val = 1; c0_req_addr = 28'h100; c1_req_val = 1; c1_req_addr = 28'h200; mem_req_rdy = 1;
    #1;
    vectors++; if (c1_req_rdy !== (first == 1) || c0_req_rdy !== (first == 0)) begin errors++; $display("FAIL dual_first_grant: got c0=%b c1=%b want winner %0d", c0_req_rdy, c1_req_rdy, first); end
    vectors++; if (mem_req_addr !== (first == 1 ? 28'h200 : 28'h100)) begin errors++; $display("FAIL dual_first_addr: got %h", mem_req_addr); end
    @(negedge clk);
    if (first == 1) c1_req_val = 0; else c0_req_val = 0;
    #1;
    vectors++; if (c1_req_rdy !== (first == 0) || c0_req_rdy !== (first == 1)) begin errors++; $display("FAIL dual_second_grant: got c0=%b c1=%b want winner %0d", c0_req_rdy, c1_req_rdy, 1 - first); end
    @(negedge clk);
    c0_req_val = 0; c1_req_val = 0;
    for (int i = 0; i < 2 * DC; i++) begin
      int id;
      id = (i < DC) ? first : 1 - first;
      mem_resp_val = 1; mem_resp_data = DB'(i); #1;
      vectors++; if (c0_resp_val !== (id == 0) || c1_resp_val !== (id == 1)) begin errors++; $display("FAIL dual_resp beat %0d: got c0=%b c1=%b want port %0d", i, c0_resp_val, c1_resp_val, id); end
      @(negedge clk);
    end
    mem_resp_val = 0;
  endtask

  task automatic test_write_burst();
    logic pat [5];
    logic [DB-1:0] exp_bits;
    int fired;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    fired = 0;
    do_reset();
    c1_req_val = 1; c1_req_rw = 1; c1_req_addr = 28'h10; mem_req_rdy = 1;
    #1;
    vectors++; if ({c1_req_rdy, mem_req_rw} !== 2'b11 || mem_req_addr !== 28'h10) begin errors++; $display("FAIL wr_grant: got rdy=%b rw=%b addr=%h want 1 1 010", c1_req_rdy, mem_req_rw, mem_req_addr); end
    @(negedge clk);
    c1_req_val = 0; c0_req_val = 1; c0_req_rw = 0; c0_req_addr = 28'h80;
    c0_data_valid = 1; c0_data_bits = '1; c0_data_mask = 16'h0;
    c1_data_valid = 1; c1_data_mask = 16'hFFFF;
    for (int c = 0; c < 5 && fired < DC; c++) begin
      exp_bits = {4{32'hD000_0000 + 32'(fired)}};
      c1_data_bits = exp_bits; mem_req_data_ready = pat[c]; #1;
      vectors++; if (mem_req_data_valid !== 1'b1 || mem_req_data_bits !== exp_bits || mem_req_data_mask !== 16'hFFFF) begin errors++; $display("FAIL wr_beat %0d: got v=%b bits=%h mask=%h", fired, mem_req_data_valid, mem_req_data_bits, mem_req_data_mask); end
      vectors++; if (c1_data_ready !== pat[c] || c0_data_ready !== 1'b0) begin errors++; $display("FAIL wr_ready cyc %0d: got c0=%b c1=%b want 0 %b", c, c0_data_ready, c1_data_ready, pat[c]); end
      vectors++; if ({mem_req_val, c0_req_rdy} !== 2'b00) begin errors++; $display("FAIL wr_blocks_req cyc %0d: got %b want 00", c, {mem_req_val, c0_req_rdy}); end
      if (pat[c]) fired++;
      @(negedge clk);
    end
    c1_data_valid = 0; c0_data_valid = 0; mem_req_data_ready = 1; #1;
    vectors++; if ({c0_req_rdy, mem_req_val, mem_req_data_valid} !== 3'b110) begin errors++; $display("FAIL wr_then_read: got %b want 110", {c0_req_rdy, mem_req_val, mem_req_data_valid}); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_fifo_full();
    do_reset();
    c0_req_val = 1; mem_req_rdy = 1;
    for (int i = 0; i < MO; i++) begin
      c0_req_addr = AB'(i); #1;
      vectors++; if (c0_req_rdy !== 1'b1) begin errors++; $display("FAIL full_fill %0d: got %b want 1", i, c0_req_rdy); end
      @(negedge clk);
    end
    #1;
    vectors++; if ({c0_req_rdy, mem_req_val} !== 2'b00) begin errors++; $display("FAIL full_hold: got %b want 00", {c0_req_rdy, mem_req_val}); end
    @(negedge clk);
    for (int i = 0; i < DC; i++) begin
      mem_resp_val = 1; mem_resp_data = DB'(i); #1;
      vectors++; if (c0_req_rdy !== 1'b0 || c0_resp_val !== 1'b1) begin errors++; $display("FAIL full_during_resp %0d: got rdy=%b resp=%b want 0 1", i, c0_req_rdy, c0_resp_val); end
      @(negedge clk);
    end
    mem_resp_val = 0; #1;
    vectors++; if (c0_req_rdy !== 1'b1) begin errors++; $display("FAIL full_release: got %b want 1", c0_req_rdy); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_arbitration();
    int q[$];
    int order[$];
    int beat, cyc, gw, want;
    beat = 0; cyc = 0;
    do_reset();
    c0_req_val = 1; c1_req_val = 1; mem_req_rdy = 1;
    while (order.size() < 6 && cyc < 200) begin
      mem_resp_val = (q.size() > 0); mem_resp_data = DB'(cyc); #1;
      vectors++; if (c0_req_rdy && c1_req_rdy) begin errors++; $display("FAIL arb_double_grant cyc %0d", cyc); end
      if (q.size() > 0) begin
        vectors++; if (c0_resp_val !== (q[0] == 0) || c1_resp_val !== (q[0] == 1)) begin errors++; $display("FAIL arb_resp cyc %0d: got c0=%b c1=%b want port %0d", cyc, c0_resp_val, c1_resp_val, q[0]); end
      end
      gw = c0_req_rdy ? 0 : (c1_req_rdy ? 1 : -1);
      if (mem_resp_val) begin
        beat++;
        if (beat == DC) begin beat = 0; void'(q.pop_front()); end
      end
      if (gw >= 0) begin order.push_back(gw); q.push_back(gw); end
      @(negedge clk);
      cyc++;
    end
    vectors++; if (order.size() != 6) begin errors++; $display("FAIL arb_timeout: got %0d grants want 6", order.size()); end
    for (int i = 0; i < order.size(); i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      want = i % 2;
`else
      want = 1;
`endif
      vectors++; if (order[i] != want) begin errors++; $display("FAIL arb_order grant %0d: got port %0d want %0d", i, order[i], want); end
    end
    idle();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    c1_req_val = 1; c1_req_addr = 28'h300; mem_req_rdy = 1; #1;
    vectors++; if (c1_req_rdy !== 1'b1) begin errors++; $display("FAIL rmb_read_grant: got %b want 1", c1_req_rdy); end
    @(negedge clk);
    c1_req_val = 0; c0_req_val = 1; c0_req_rw = 1; c0_req_addr = 28'h20; #1;
    vectors++; if (c0_req_rdy !== 1'b1) begin errors++; $display("FAIL rmb_write_grant: got %b want 1", c0_req_rdy); end
    @(negedge clk);
    c0_req_val = 0; c0_data_valid = 1; c0_data_mask = 16'hFFFF; mem_req_data_ready = 1;
    for (int i = 0; i < 2; i++) begin
      c0_data_bits = DB'(i); #1;
      vectors++; if (c0_data_ready !== 1'b1) begin errors++; $display("FAIL rmb_beat %0d: got %b want 1", i, c0_data_ready); end
      @(negedge clk);
    end
    c1_req_val = 1; #1;
    rst_n = 0; #1;
    vectors++; if ({mem_req_val, c0_req_rdy, c1_req_rdy, mem_req_data_valid, c0_data_ready, c1_data_ready} !== 6'b0) begin errors++; $display("FAIL rmb_outputs_in_reset: got %b want 000000", {mem_req_val, c0_req_rdy, c1_req_rdy, mem_req_data_valid, c0_data_ready, c1_data_ready}); end
    @(negedge clk);
    rst_n = 1; idle();
    c0_req_val = 1; c0_req_addr = 28'h400; mem_req_rdy = 1; #1;
    vectors++; if ({c0_req_rdy, mem_req_rw} !== 2'b10) begin errors++; $display("FAIL rmb_after_reset_grant: got %b want 10", {c0_req_rdy, mem_req_rw}); end
    @(negedge clk);
    c0_req_val = 0;
    for (int i = 0; i < DC; i++) begin
      mem_resp_val = 1; mem_resp_data = DB'(i); #1;
      vectors++; if ({c0_resp_val, c1_resp_val} !== 2'b10) begin errors++; $display("FAIL rmb_fifo_cleared beat %0d: got %b want 10", i, {c0_resp_val, c1_resp_val}); end
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_random();
    int q[$];
    int beat;
    logic e0, e1, exp_any, exp_w, full;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic favor;
    favor = 1'b0;
`endif
    beat = 0;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      c0_req_val = 1'($urandom_range(0, 1)); c0_req_addr = AB'($urandom);
      c1_req_val = 1'($urandom_range(0, 1)); c1_req_addr = AB'($urandom);
      mem_req_rdy = ($urandom_range(0, 3) != 0);
      mem_resp_val = (q.size() > 0) && ($urandom_range(0, 2) != 0);
      mem_resp_data = {$urandom, $urandom, $urandom, $urandom};
      #1;
      full = (q.size() >= MO);
      e0 = c0_req_val && !full;
      e1 = c1_req_val && !full;
      exp_any = e0 || e1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_w = (e0 && e1) ? favor : e1;
`else
      exp_w = e1;
`endif
      vectors++; if (mem_req_val !== exp_any) begin errors++; $display("FAIL rnd_req_val cyc %0d: got %b want %b", cyc, mem_req_val, exp_any); end
      vectors++; if (c0_req_rdy !== (exp_any && !exp_w && mem_req_rdy) || c1_req_rdy !== (exp_any && exp_w && mem_req_rdy)) begin errors++; $display("FAIL rnd_rdy cyc %0d: got c0=%b c1=%b", cyc, c0_req_rdy, c1_req_rdy); end
      if (exp_any) begin
        vectors++; if (mem_req_addr !== (exp_w ? c1_req_addr : c0_req_addr)) begin errors++; $display("FAIL rnd_addr cyc %0d: got %h", cyc, mem_req_addr); end
      end
      vectors++; if (c0_resp_val !== (mem_resp_val && q[0] == 0) || c1_resp_val !== (mem_resp_val && q[0] == 1)) begin errors++; $display("FAIL rnd_resp cyc %0d: got c0=%b c1=%b", cyc, c0_resp_val, c1_resp_val); end
      if (mem_resp_val) begin
        vectors++; if (c0_resp_data !== mem_resp_data || c1_resp_data !== mem_resp_data) begin errors++; $display("FAIL rnd_resp_data cyc %0d", cyc); end
        beat++;
        if (beat == DC) begin beat = 0; void'(q.pop_front()); end
      end
      if (exp_any && mem_req_rdy) begin
        q.push_back(int'(exp_w));
`ifdef MEM_ARB_ROUND_ROBIN_EN
        favor = !exp_w;
`endif
      end
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    rst_n = 0;
    idle();
    test_reset();
    test_single_read();
    test_dual_read();
    test_write_burst();
    test_fifo_full();
    test_arbitration();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
